// File: rtl/lipsi_ctrl_fsm.sv
// Lipsi multi-cycle control FSM: decodes the instruction byte and sequences PC,
// accumulator, memory-write and ALU controls with wait states, single-step and halt.
module lipsi_ctrl_fsm #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        instruction,
  input  logic [DATA_W-1:0] A,
  input  logic              mem_rdy,
  input  logic              step_mode,
  input  logic              step,
  output logic [1:0]        mux_pc_rd,
  output logic              wr_addr,
  output logic              wr_data,
  output logic              pc_en,
  output logic              acc_en,
  output logic              fetch,
  output logic              small_addr,
  output logic [3:0]        alu_ctrl,
  output logic [3:0]        state,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [3:0] {
    S_DEC  = 4'd0,
    S_ALU  = 4'd1,
    S_ST   = 4'd2,
    S_BRL  = 4'd3,
    S_LDI1 = 4'd4,
    S_LDI2 = 4'd5,
    S_STI1 = 4'd6,
    S_STI2 = 4'd7,
    S_IMM  = 4'd8,
    S_BR_T = 4'd9,
    S_BR_N = 4'd10,
    S_HALT = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       alu_q, alu_d;
  logic [CNT_W-1:0] ret_q;
  logic             hold, retire, a_zero;
  logic [1:0]       mux_r;
  logic             wa_r, wd_r, pe_r, ae_r, fe_r, sa_r, ha_r;
  logic             unused_instr_bit;

  assign unused_instr_bit = instruction[3];
  assign a_zero = (A == '0);

  // Wait states hold every non-halt state; step mode additionally holds DEC until a pulse.
  assign hold = (!mem_rdy && state_q != S_HALT) ||
                (state_q == S_DEC && step_mode && !step);

  assign retire = (state_q != S_HALT) && (state_d == S_DEC || state_d == S_HALT);

  always_comb begin
    state_d = S_DEC;
    alu_d   = '0;
    mux_r   = 2'b00;
    wa_r    = 1'b0;
    wd_r    = 1'b0;
    pe_r    = 1'b0;
    ae_r    = 1'b0;
    fe_r    = 1'b0;
    sa_r    = 1'b1;
    ha_r    = 1'b0;
    case (state_q)
      S_DEC: begin
        casez (instruction[7:4])
          4'b0???: begin
            mux_r   = 2'b10;
            alu_d   = {1'b1, instruction[6:4]};
            state_d = S_ALU;
          end
          4'b1000: begin
            wa_r    = 1'b1;
            mux_r   = 2'b10;
            state_d = S_ST;
          end
          4'b1001: begin
            mux_r   = 2'b01;
            wa_r    = 1'b1;
            wd_r    = 1'b1;
            state_d = S_BRL;
          end
          4'b1010: begin
            mux_r   = 2'b10;
            state_d = S_LDI1;
          end
          4'b1011: begin
            mux_r   = 2'b10;
            state_d = S_STI1;
          end
          4'b1100: begin
            pe_r    = 1'b1;
            fe_r    = 1'b1;
            alu_d   = {1'b1, instruction[2:0]};
            state_d = S_IMM;
          end
          4'b1101: begin
            pe_r = 1'b1;
            fe_r = 1'b1;
            case (instruction[1:0])
              2'b00:   state_d = S_BR_T;
              2'b10:   state_d = a_zero ? S_BR_T : S_BR_N;
              2'b11:   state_d = a_zero ? S_BR_N : S_BR_T;
              default: state_d = S_BR_N;
            endcase
          end
          4'b1110: begin
            pe_r    = 1'b1;
            ae_r    = 1'b1;
            fe_r    = 1'b1;
            alu_d   = {2'b01, instruction[1:0]};
            state_d = S_DEC;
          end
          default: begin
            mux_r   = 2'b10;
            fe_r    = 1'b1;
            state_d = S_HALT;
          end
        endcase
      end
      S_ALU, S_IMM, S_LDI2: begin
        pe_r = 1'b1;
        ae_r = 1'b1;
        fe_r = 1'b1;
      end
      S_ST, S_STI2, S_BR_N: begin
        pe_r = 1'b1;
        fe_r = 1'b1;
      end
      S_BRL: begin
        mux_r = 2'b01;
        pe_r  = 1'b1;
        fe_r  = 1'b1;
      end
      S_BR_T: begin
        mux_r = 2'b10;
        pe_r  = 1'b1;
        fe_r  = 1'b1;
      end
      S_LDI1: begin
        mux_r   = 2'b01;
        sa_r    = 1'b0;
        state_d = S_LDI2;
      end
      S_STI1: begin
        wa_r    = 1'b1;
        sa_r    = 1'b0;
        state_d = S_STI2;
      end
      S_HALT: begin
        mux_r   = 2'b11;
        fe_r    = 1'b1;
        ha_r    = 1'b1;
        state_d = S_HALT;
      end
      default: state_d = S_DEC;
    endcase
  end

  // Reset forces the idle output pattern combinationally, independent of the clock.
  always_comb begin
    mux_pc_rd  = mux_r;
    small_addr = sa_r;
    wr_data    = wd_r;
    fetch      = fe_r;
    pc_en      = pe_r & ~hold;
    acc_en     = ae_r & ~hold;
    wr_addr    = wa_r & ~hold;
    halted     = ha_r;
    if (reset) begin
      mux_pc_rd  = 2'b00;
      small_addr = 1'b1;
      wr_data    = 1'b0;
      fetch      = 1'b0;
      pc_en      = 1'b0;
      acc_en     = 1'b0;
      wr_addr    = 1'b0;
      halted     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_DEC;
      alu_q   <= '0;
      ret_q   <= '0;
    end else if (!hold) begin
      state_q <= state_d;
      if (state_q == S_DEC)
        alu_q <= alu_d;
      if (retire && ret_q != '1)
        ret_q <= ret_q + CNT_W'(1);
    end
  end

  assign state    = state_q;
  assign alu_ctrl = alu_q;
  assign retired  = ret_q;

endmodule

// File: tb/tb_lipsi_ctrl_fsm.sv
// Bench for lipsi_ctrl_fsm: two instances (8-bit/16-bit counter, 16-bit/2-bit counter)
// driven in lockstep and compared every cycle against a phase-queue reference model.
module tb_lipsi_ctrl_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  instruction = '0;
  logic [15:0] A16 = '0;
  logic [7:0]  A8;
  logic        mem_rdy = 1'b1;
  logic        step_mode = 1'b0;
  logic        step = 1'b0;

  assign A8 = A16[7:0];

  logic [1:0]  mux_0, mux_1;
  logic        wa_0, wd_0, pe_0, ae_0, fe_0, sa_0, ha_0;
  logic        wa_1, wd_1, pe_1, ae_1, fe_1, sa_1, ha_1;
  logic [3:0]  alu_0, alu_1, st_0, st_1;
  logic [15:0] ret_0;
  logic [1:0]  ret_1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  lipsi_ctrl_fsm #(.DATA_W(8), .CNT_W(16)) u_dut8 (
    .clk(clk), .reset(reset), .instruction(instruction), .A(A8),
    .mem_rdy(mem_rdy), .step_mode(step_mode), .step(step),
    .mux_pc_rd(mux_0), .wr_addr(wa_0), .wr_data(wd_0), .pc_en(pe_0),
    .acc_en(ae_0), .fetch(fe_0), .small_addr(sa_0), .alu_ctrl(alu_0),
    .state(st_0), .halted(ha_0), .retired(ret_0)
  );

  lipsi_ctrl_fsm #(.DATA_W(16), .CNT_W(2)) u_dut16 (
    .clk(clk), .reset(reset), .instruction(instruction), .A(A16),
    .mem_rdy(mem_rdy), .step_mode(step_mode), .step(step),
    .mux_pc_rd(mux_1), .wr_addr(wa_1), .wr_data(wd_1), .pc_en(pe_1),
    .acc_en(ae_1), .fetch(fe_1), .small_addr(sa_1), .alu_ctrl(alu_1),
    .state(st_1), .halted(ha_1), .retired(ret_1)
  );

  // Reference model: pending execute phases per instance (empty = decoding).
  int         m_pend[2][2];
  int         m_np[2];
  bit         m_halt[2];
  logic [3:0] m_alu[2];
  int         m_ret[2];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_np[k] = 0; m_halt[k] = 0; m_alu[k] = '0; m_ret[k] = 0;
    end
  endfunction

  function automatic int model_state(int k);
    if (m_halt[k]) return 11;
    if (m_np[k] > 0) return m_pend[k][0];
    return 0;
  endfunction

  function automatic bit model_stalled(int k);
    if (m_halt[k]) return 0;
    return !mem_rdy || (m_np[k] == 0 && step_mode && !step);
  endfunction

  function automatic bit model_taken(int k);
    bit az = (k == 0) ? (A16[7:0] == 8'h00) : (A16 == 16'h0000);
    case (instruction[1:0])
      2'd0: return 1;
      2'd2: return az;
      2'd3: return !az;
      default: return 0;
    endcase
  endfunction

  // Packed {mux[1:0], wr_addr, wr_data, pc_en, acc_en, fetch, small_addr, halted}
  function automatic logic [8:0] model_outs(int k);
    logic [1:0] mux = 2'd0;
    bit wa = 0, wd = 0, pe = 0, ae = 0, fe = 0, sa = 1, ha = 0;
    int op = int'(instruction[7:4]);
    if (reset) return {2'd0, 7'b0000010};
    if (m_halt[k]) begin
      mux = 2'd3; fe = 1; ha = 1;
    end else if (m_np[k] == 0) begin
      if (op < 8) mux = 2'd2;
      else case (op)
        8:      begin wa = 1; mux = 2'd2; end
        9:      begin mux = 2'd1; wa = 1; wd = 1; end
        10, 11: mux = 2'd2;
        12, 13: begin pe = 1; fe = 1; end
        14:     begin pe = 1; ae = 1; fe = 1; end
        default: begin mux = 2'd2; fe = 1; end
      endcase
    end else begin
      case (m_pend[k][0])
        1, 5, 8:  begin pe = 1; ae = 1; fe = 1; end
        2, 7, 10: begin pe = 1; fe = 1; end
        3:        begin mux = 2'd1; pe = 1; fe = 1; end
        9:        begin mux = 2'd2; pe = 1; fe = 1; end
        4:        begin mux = 2'd1; sa = 0; end
        default:  begin wa = 1; sa = 0; end
      endcase
    end
    if (model_stalled(k)) begin pe = 0; ae = 0; wa = 0; end
    return {mux, wa, wd, pe, ae, fe, sa, ha};
  endfunction

  function automatic void model_retire(int k);
    int lim = (k == 0) ? 65535 : 3;
    if (m_ret[k] < lim) m_ret[k]++;
  endfunction

  function automatic void model_clock(int k);
    int op = int'(instruction[7:4]);
    if (m_halt[k] || model_stalled(k)) return;
    if (m_np[k] == 0) begin
      if (op < 8)        m_alu[k] = {1'b1, instruction[6:4]};
      else if (op == 12) m_alu[k] = {1'b1, instruction[2:0]};
      else if (op == 14) m_alu[k] = {2'b01, instruction[1:0]};
      else               m_alu[k] = 4'd0;
      case (op)
        8:  begin m_pend[k][0] = 2; m_np[k] = 1; end
        9:  begin m_pend[k][0] = 3; m_np[k] = 1; end
        10: begin m_pend[k][0] = 4; m_pend[k][1] = 5; m_np[k] = 2; end
        11: begin m_pend[k][0] = 6; m_pend[k][1] = 7; m_np[k] = 2; end
        12: begin m_pend[k][0] = 8; m_np[k] = 1; end
        13: begin m_pend[k][0] = model_taken(k) ? 9 : 10; m_np[k] = 1; end
        14: model_retire(k);
        15: begin m_halt[k] = 1; model_retire(k); end
        default: begin m_pend[k][0] = 1; m_np[k] = 1; end
      endcase
    end else begin
      m_pend[k][0] = m_pend[k][1];
      m_np[k]--;
      if (m_np[k] == 0) model_retire(k);
    end
  endfunction

  task automatic check_all();
    chk_val("outs8", {mux_0, wa_0, wd_0, pe_0, ae_0, fe_0, sa_0, ha_0}, model_outs(0));
    chk_val("state8", st_0, model_state(0));
    chk_val("alu8", alu_0, m_alu[0]);
    chk_val("ret8", ret_0, m_ret[0]);
    chk_val("outs16", {mux_1, wa_1, wd_1, pe_1, ae_1, fe_1, sa_1, ha_1}, model_outs(1));
    chk_val("state16", st_1, model_state(1));
    chk_val("alu16", alu_1, m_alu[1]);
    chk_val("ret16", ret_1, m_ret[1]);
  endtask

  // Called at posedge+1; checks before the next edge, clocks model, returns at posedge+1.
  task automatic tick();
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_clock(0);
    model_clock(1);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    check_all();
    #1;
    reset = 1'b0;
  endtask

  task automatic run(input logic [7:0] ins, input int n);
    instruction = ins;
    for (int i = 0; i < n; i++) tick();
  endtask

  int saved;

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // add r3 then shift
    run(8'h23, 1);
    chk_val("add.alu", alu_0, 32'hA);
    chk_val("add.state", st_0, 32'd1);
    run(8'hE1, 1);
    run(8'hE1, 1);
    chk_val("shift.alu", alu_0, 32'h5);
    chk_val("shift.ret", ret_0, 32'd2);

    // reset in the middle of an indirect load
    run(8'hA5, 1);
    chk_val("ldi1.state", st_0, 32'd4);
    reset = 1'b1;
    #1;
    chk_val("rst.state", st_0, 32'd0);
    chk_val("rst.en", {pe_0, ae_0, wa_0, fe_0}, 32'd0);
    model_reset();
    #1;
    reset = 1'b0;
    run(8'h23, 1);
    chk_val("post_rst.state", st_0, 32'd1);
    run(8'h23, 1);

    // branches
    A16 = 16'h0000; run(8'hD2, 1);
    chk_val("brz0.state", st_0, 32'd9);
    run(8'h00, 1);
    A16 = 16'h0001; run(8'hD2, 1);
    chk_val("brz1.state", st_0, 32'd10);
    run(8'h00, 1);
    A16 = 16'h0100; run(8'hD3, 1);
    chk_val("brnz16.state", st_1, 32'd9);
    chk_val("brnz8.state", st_0, 32'd10);
    run(8'h00, 1);
    run(8'hD1, 1);
    chk_val("brres.state", st_0, 32'd10);
    run(8'h00, 1);

    // indirect load with three wait states in LDI1
    saved = ret_0;
    run(8'hA5, 1);
    mem_rdy = 1'b0; run(8'hA5, 3);
    mem_rdy = 1'b1; run(8'hA5, 1);
    chk_val("ldi2.state", st_0, 32'd5);
    run(8'hA5, 1);
    chk_val("ldi.ret", ret_0, 32'(saved + 1));

    // single step on a store
    step_mode = 1'b1; step = 1'b0;
    saved = ret_0;
    run(8'h80, 3);
    chk_val("step.hold", st_0, 32'd0);
    step = 1'b1; run(8'h80, 1);
    step = 1'b0;
    chk_val("step.st", st_0, 32'd2);
    run(8'h80, 3);
    chk_val("step.ret", ret_0, 32'(saved + 1));
    step_mode = 1'b0;

    // counter saturation on the 2-bit instance
    do_reset();
    run(8'hE0, 5);
    chk_val("sat16", ret_1, 32'd3);
    chk_val("sat8", ret_0, 32'd5);

    // exit and halt
    run(8'hFF, 1);
    saved = ret_0;
    for (int i = 0; i < 100; i++) begin
      mem_rdy = 1'($urandom_range(0, 1));
      instruction = 8'($urandom);
      tick();
    end
    mem_rdy = 1'b1;
    chk_val("halt.state", st_0, 32'd11);
    chk_val("halt.flag", ha_0, 32'd1);
    chk_val("halt.ret", ret_0, saved);

    // randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      instruction = 8'($urandom);
      if (instruction[7:4] == 4'hF && $urandom_range(0, 3) != 0) instruction[7:4] = 4'hE;
      mem_rdy = ($urandom_range(0, 3) != 0);
      if (i % 64 == 0) step_mode = ($urandom_range(0, 2) == 0);
      step = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0: A16 = 16'h0000;
        1: A16 = 16'h0100;
        2: A16 = 16'($urandom);
        default: A16 = 16'($urandom_range(0, 3));
      endcase
      if ((m_halt[0] && $urandom_range(0, 5) == 0) || $urandom_range(0, 149) == 0)
        do_reset();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
